dmem_arbiter: RTL and testbench

Shares the single-port synchronous data memory (dmem) between two requesters: port 0 is the processor's load/store path and port 1 is a loader/debug master that fills or inspects dmem. It grants at most one access per cycle with round-robin fairness and registers the memory command. It also tracks in-flight reads across the memory's registered-read latency and returns read data to the requester that issued each read. It sits between the processor/loader and `dmem`, all in the dmem clock domain.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/rr_arbiter_2.sv | 21 ++
 rtl/dmem_arbiter.sv | 100 ++++++++++
 tb/tb_dmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the dmem arbiter: default widths, port
// indices and the read-tag that follows each read through the memory latency.
package dmem_arb_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  localparam logic PORT_PROC = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker: a lone requester always wins, and on a tie
// the port that was not granted most recently wins.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // NOTE: gnt gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between the processor (port 0) and the loader
// (port 1): one registered command per cycle, read data steered back by tag.
module dmem_arbiter #(
  parameter int ADDR_W = dmem_arb_pkg::ADDR_W,
  parameter int DATA_W = dmem_arb_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  import dmem_arb_pkg::*;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              last;
  logic              granted;
  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  rd_tag_t           tag_q1;
  rd_tag_t           tag_q2;

  // Requests are masked during reset so no grant is ever issued then.
  assign req = {p1_req, p0_req} & {2{~reset}};

  rr_arbiter_2 u_rr (
    .req  (req),
    .last (last),
    .gnt  (gnt)
  );

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign granted   = |gnt;
  assign sel       = gnt[1];
  assign sel_we    = sel ? p1_we    : p0_we;
  assign sel_addr  = sel ? p1_addr  : p0_addr;
  assign sel_wdata = sel ? p1_wdata : p0_wdata;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      last <= PORT_LOAD;
    end else if (granted) begin
      last <= sel;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
    end else begin
      mem_wren <= granted & sel_we;
      if (granted) begin
        mem_address <= sel_addr;
        mem_data    <= sel_wdata;
      end
    end
  end

  // NOTE: the tag stages are cleared on reset (unlike dmem itself) so a read
  // that was in flight when reset arrived never raises rvalid afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      tag_q1 <= '0;
      tag_q2 <= '0;
    end else begin
      tag_q1 <= '{valid: granted & ~sel_we, port: sel};
      tag_q2 <= tag_q1;
    end
  end

  assign p0_rvalid = tag_q2.valid & (tag_q2.port == PORT_PROC);
  assign p1_rvalid = tag_q2.valid & (tag_q2.port == PORT_LOAD);
  assign p0_rdata  = p0_rvalid ? mem_q : '0;
  assign p1_rdata  = p1_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural dmem, a transaction-level model checked
// every cycle, and directed scenarios with literal expectations.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [11:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic [11:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic [31:0] mem_q;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  dmem_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .p0_req      (p0_req),
    .p0_we       (p0_we),
    .p0_addr     (p0_addr),
    .p0_wdata    (p0_wdata),
    .p0_gnt      (p0_gnt),
    .p0_rvalid   (p0_rvalid),
    .p0_rdata    (p0_rdata),
    .p1_req      (p1_req),
    .p1_we       (p1_we),
    .p1_addr     (p1_addr),
    .p1_wdata    (p1_wdata),
    .p1_gnt      (p1_gnt),
    .p1_rvalid   (p1_rvalid),
    .p1_rdata    (p1_rdata),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] init_word(input int a);
    return 32'hC0DE0000 ^ 32'(a * 32'h0001_0203);
  endfunction

  // Behavioural dmem: no reset, registered read.
  logic [31:0] dmem [4096];
  always @(posedge clock) begin
    if (mem_wren) dmem[mem_address] <= mem_data;
    mem_q <= dmem[mem_address];
  end

  // Transaction-level model: a grant applies the access to the model memory
  // at once; a read is due back on its port two cycles later.
  logic [31:0] m_mem [4096];
  int          m_last = 1;
  logic [11:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        exp_wren = 1'b0;
  int          cyc = 0;
  int          due_port [int];
  logic [31:0] due_data [int];

  always @(negedge clock) begin
    int winner;
    logic [1:0] exp_rv;
    logic [31:0] exp_rd;
    winner = -1;
    if (!reset) begin
      if (p0_req && p1_req) winner = 1 - m_last;
      else if (p0_req) winner = 0;
      else if (p1_req) winner = 1;
    end
    exp_rv = 2'b00;
    exp_rd = '0;
    if (due_port.exists(cyc)) begin
      exp_rv[due_port[cyc]] = 1'b1;
      exp_rd = due_data[cyc];
      due_port.delete(cyc);
      due_data.delete(cyc);
    end
    check("model_p0_gnt", 32'(p0_gnt), 32'(winner == 0));
    check("model_p1_gnt", 32'(p1_gnt), 32'(winner == 1));
    check("model_mem_wren", 32'(mem_wren), 32'(exp_wren));
    check("model_mem_address", 32'(mem_address), 32'(exp_addr));
    check("model_mem_data", mem_data, exp_data);
    check("model_p0_rvalid", 32'(p0_rvalid), 32'(exp_rv[0]));
    check("model_p1_rvalid", 32'(p1_rvalid), 32'(exp_rv[1]));
    check("model_p0_rdata", p0_rdata, exp_rv[0] ? exp_rd : 32'h0);
    check("model_p1_rdata", p1_rdata, exp_rv[1] ? exp_rd : 32'h0);
    check("model_rvalid_exclusive", 32'(p0_rvalid & p1_rvalid), 32'h0);

    if (reset) begin
      m_last   = 1;
      exp_addr = '0;
      exp_data = '0;
      exp_wren = 1'b0;
      if (due_port.exists(cyc + 1)) begin
        due_port.delete(cyc + 1);
        due_data.delete(cyc + 1);
      end
    end else if (winner >= 0) begin
      logic        w_we;
      logic [11:0] w_addr;
      logic [31:0] w_data;
      w_we   = (winner == 1) ? p1_we    : p0_we;
      w_addr = (winner == 1) ? p1_addr  : p0_addr;
      w_data = (winner == 1) ? p1_wdata : p0_wdata;
      m_last   = winner;
      exp_addr = w_addr;
      exp_data = w_data;
      exp_wren = w_we;
      if (w_we) m_mem[w_addr] = w_data;
      else begin
        due_port[cyc + 2] = winner;
        due_data[cyc + 2] = m_mem[w_addr];
      end
    end else begin
      exp_wren = 1'b0;
    end
    cyc++;
  end

  task automatic cyc_start();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  int order [8];
  int k0, k1, n0, wait1;
  logic p1_done;

  initial begin
    for (int a = 0; a < 4096; a++) begin
      dmem[a]  = init_word(a);
      m_mem[a] = init_word(a);
    end
    dmem[12'h010]  = 32'hDEADBEEF;
    m_mem[12'h010] = 32'hDEADBEEF;

    // Reset held three cycles with both ports requesting.
    reset = 1'b1;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h020; p0_wdata = '0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 12'h021; p1_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      settle();
      if (i > 0) begin
        check("reset_no_gnt", 32'({p1_gnt, p0_gnt}), 32'h0);
        check("reset_wren", 32'(mem_wren), 32'h0);
        check("reset_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'h0);
      end
      cyc_start();
    end
    reset = 1'b0;
    settle();
    check("first_gnt_port0", 32'({p1_gnt, p0_gnt}), 32'h1);
    cyc_start();
    p0_req = 1'b0;
    settle();
    check("then_gnt_port1", 32'({p1_gnt, p0_gnt}), 32'h2);
    cyc_start();
    p1_req = 1'b0;
    repeat (2) cyc_start();

    // Single read by port 0.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h010;
    settle();
    check("single_gnt", 32'(p0_gnt), 32'h1);
    cyc_start();
    p0_req = 1'b0;
    settle();
    check("single_addr", 32'(mem_address), 32'h010);
    check("single_wren", 32'(mem_wren), 32'h0);
    cyc_start();
    settle();
    check("single_rvalid", 32'(p0_rvalid), 32'h1);
    check("single_rdata", p0_rdata, 32'hDEADBEEF);
    check("single_p1_quiet", 32'(p1_rvalid), 32'h0);
    cyc_start();

    // Port 1 writes then reads the same address back to back.
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 12'h0FF; p1_wdata = 32'h12345678;
    settle();
    check("wr_gnt", 32'(p1_gnt), 32'h1);
    cyc_start();
    p1_we = 1'b0;
    settle();
    check("rd_gnt", 32'(p1_gnt), 32'h1);
    check("wr_wren", 32'(mem_wren), 32'h1);
    check("wr_data", mem_data, 32'h12345678);
    cyc_start();
    p1_req = 1'b0;
    settle();
    check("wr_wren_once", 32'(mem_wren), 32'h0);
    cyc_start();
    settle();
    check("raw_rdata", p1_rdata, 32'h12345678);
    cyc_start();

    // Contention: four back-to-back reads on each port.
    k0 = 0; k1 = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc_start();
      p0_req = (k0 < 4); p0_we = 1'b0; p0_addr = 12'h100 + 12'(k0);
      p1_req = (k1 < 4); p1_we = 1'b0; p1_addr = 12'h200 + 12'(k1);
      settle();
      order[c] = p1_gnt ? 1 : (p0_gnt ? 0 : -1);
      if (p0_gnt) k0++;
      if (p1_gnt) k1++;
    end
    cyc_start();
    p0_req = 1'b0; p1_req = 1'b0;
    for (int c = 0; c < 8; c++) check($sformatf("contention_order_%0d", c), 32'(order[c]), 32'(c % 2));
    repeat (3) cyc_start();

    // Reset arrives the cycle after a read grant.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 12'h030;
    settle();
    check("mid_gnt", 32'(p0_gnt), 32'h1);
    cyc_start();
    p0_req = 1'b0; reset = 1'b1;
    cyc_start();
    reset = 1'b0;
    settle();
    check("mid_no_rvalid", 32'(p0_rvalid), 32'h0);
    check("mid_wren", 32'(mem_wren), 32'h0);
    check("mid_addr", 32'(mem_address), 32'h0);
    cyc_start();

    // Port 1 holds a read while port 0 streams three accesses.
    n0 = 0; wait1 = 0; p1_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) cyc_start();
      p0_req = (n0 < 3); p0_we = (n0 == 0);
      p0_addr = 12'h040 + 12'(n0); p0_wdata = 32'hAAAA0000 + 32'(n0);
      p1_req = !p1_done; p1_we = 1'b0; p1_addr = 12'h0FF;
      settle();
      if (p0_gnt) n0++;
      if (p1_req && !p1_gnt) wait1++;
      if (p1_gnt) p1_done = 1'b1;
    end
    cyc_start();
    p0_req = 1'b0; p1_req = 1'b0;
    check("hold_p1_granted", 32'(p1_done), 32'h1);
    check("hold_p1_wait", 32'(wait1), 32'h1);
    check("hold_p0_done", 32'(n0), 32'h3);

    repeat (4) cyc_start();
    check("all_reads_returned", 32'(due_port.num()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
